display_scan_ctrl: RTL



---
 rtl/display_scan_ctrl_pkg.sv | 24 ++
 rtl/display_scan_ctrl_hex7seg.sv | 37 +++
 rtl/display_scan_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// ============================================================================
// disp_pkg : shared types and constants for display_scan_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Returns n ones in the low bits; callers slice off their digit count (n <= 8).
  function automatic logic [7:0] an_off(input int unsigned n);
    return 8'hFF >> (8 - n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_hex7seg.sv
// ============================================================================
// hex7seg : nibble to active-low 7-segment pattern, seg[6]=a .. seg[0]=g
// Rev 1.0
// ============================================================================
`default_nettype none

module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// display_scan_ctrl : multiplexed common-anode 7-seg scanner, frame-aligned loads
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits. Rev 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               enable,
  input  logic                                               load_valid,
  output logic                                               load_ready,
  input  logic [4*NUM_DIGITS-1:0]                            load_data,
  output logic [6:0]                                         seg,
  output logic [NUM_DIGITS-1:0]                              an,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [7:0]            c_an_all    = an_off(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] c_an_off    = c_an_all[NUM_DIGITS-1:0];
  localparam logic [CW-1:0]         c_show_last = CW'(PRESCALE - BLANK_CYC - 1);
  localparam logic [CW-1:0]         c_slot_last = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]         c_idx_last  = IW'(NUM_DIGITS - 1);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [DW-1:0]   r_disp, w_disp_nxt;
  logic [DW-1:0]   r_pend, w_pend_nxt;
  logic            r_pend_valid, w_pend_valid_nxt;
  logic            w_ready_nxt;
  logic            w_xfer;
  logic [3:0]      w_nib;
  logic [6:0]      w_seg_dec;
  logic            w_show;

  assign w_xfer = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      digit_idx    <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      load_ready   <= 1'b1;
      an           <= c_an_off;
      seg          <= SEG_OFF;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      digit_idx    <= w_idx_nxt;
      r_disp       <= w_disp_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      load_ready   <= w_ready_nxt;
      an           <= w_show ? ~(NUM_DIGITS'(1) << w_idx_nxt) : c_an_off;
      seg          <= w_show ? w_seg_dec : SEG_OFF;
    end
  end

  // Ready drops on the capture edge and only returns one cycle after the
  // pending value has been consumed, hence the default from the old flag.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt + CW'(1);
    w_idx_nxt        = digit_idx;
    w_disp_nxt       = r_disp;
    w_pend_nxt       = r_pend;
    w_pend_valid_nxt = r_pend_valid;
    w_ready_nxt      = ~r_pend_valid;
    if (!enable) begin
      w_state_nxt      = IDLE;
      w_cnt_nxt        = '0;
      w_idx_nxt        = '0;
      if (w_xfer)            w_disp_nxt = load_data;
      else if (r_pend_valid) w_disp_nxt = r_pend;
      w_pend_valid_nxt = 1'b0;
      w_ready_nxt      = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          if (w_xfer) w_disp_nxt = load_data;
        end
        SHOW: begin
          if (r_cnt == c_show_last) w_state_nxt = GAP;
        end
        GAP: begin
          if (r_cnt == c_slot_last) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = '0;
            if (digit_idx == c_idx_last) begin
              w_idx_nxt = '0;
              if (r_pend_valid) begin
                w_disp_nxt       = r_pend;
                w_pend_valid_nxt = 1'b0;
              end
            end else begin
              w_idx_nxt = digit_idx + IW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
      if (w_xfer && (r_state != IDLE)) begin
        w_pend_nxt       = load_data;
        w_pend_valid_nxt = 1'b1;
        w_ready_nxt      = 1'b0;
      end
    end
  end

  // Decode from next-cycle values so a frame-boundary swap shows on digit 0 at once.
  assign w_nib = w_disp_nxt[4*w_idx_nxt +: 4];

  hex7seg u_hex7seg (
    .nibble (w_nib),
    .seg    (w_seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lead_zero;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
    assign w_lead_zero[gi] = (w_disp_nxt[DW-1:4*gi] == '0);
  end

  assign w_show = (w_state_nxt == SHOW) &&
                  !((w_idx_nxt != '0) && w_lead_zero[w_idx_nxt]);
`else
  assign w_show = (w_state_nxt == SHOW);
`endif

endmodule

`default_nettype wire
